waste_code_packer: RTL

Front-end producer for the waste sorting pipeline: accepts classified items from the sensor/classifier stage and emits the 8-bit `in_waste` code words that the `WasteSorting` block consumes. Items up to 255 weight units are buffered in a small FIFO and split into chunks that fit the sorter's 4-bit weight field. The block adds a valid/ready handshake on its input and its output so that sorter stalls do not drop items.

---
 rtl/waste_pkg.sv | 51 +++++
 rtl/waste_item_fifo.sv | 66 ++++++
 rtl/waste_code_packer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/waste_pkg.sv
// Shared types and constants for the waste code packer.
//   - category / subtype codes used in the 8-bit code word
//   - MAX_CHUNK: largest weight a single code word can carry
//   - waste_item_t: packed {cat, sub, weight} item held in the FIFO
//   - helpers for subtype normalisation and chunk sizing
package waste_pkg;

  typedef enum logic [1:0] {
    CAT_RECYCLED  = 2'b00,
    CAT_ORGANIC   = 2'b01,
    CAT_HAZARDOUS = 2'b10,
    CAT_OTHER     = 2'b11
  } waste_cat_e;

  localparam logic [1:0] SUB_PLASTIC    = 2'b00;
  localparam logic [1:0] SUB_GLASS      = 2'b01;
  localparam logic [1:0] SUB_PAPER      = 2'b10;
  localparam logic [1:0] SUB_METAL      = 2'b11;
  localparam logic [1:0] SUB_ELECTRONIC = 2'b00;
  localparam logic [1:0] SUB_MEDICAL    = 2'b10;
  localparam logic [1:0] SUB_ORGANIC    = 2'b00;
  localparam logic [1:0] SUB_OTHER      = 2'b11;

  localparam logic [3:0] MAX_CHUNK = 4'd15;

  typedef struct packed {
    logic [1:0] cat;
    logic [1:0] sub;
    logic [7:0] weight;
  } waste_item_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } pack_state_e;

  // Organic and other carry a fixed subtype; the rest pass through.
  function automatic logic [1:0] norm_sub(input logic [1:0] cat, input logic [1:0] sub);
    logic [1:0] r;
    r = sub;
    if (cat == CAT_ORGANIC) r = SUB_ORGANIC;
    else if (cat == CAT_OTHER) r = SUB_OTHER;
    return r;
  endfunction

  // min(rem, 15)
  function automatic logic [3:0] chunk_of(input logic [7:0] rem);
    return (rem > {4'd0, MAX_CHUNK}) ? MAX_CHUNK : rem[3:0];
  endfunction

endpackage

// File: rtl/waste_item_fifo.sv
// Synchronous FIFO of waste_item_t entries.
//   clk, rst (async, active-low)
//   push/din : write an entry (ignored when full)
//   pop/dout : dout is the head entry; pop advances (ignored when empty)
//   full, empty : occupancy flags
// DEPTH must be a power of two, >= 2, so the pointers wrap naturally.
module waste_item_fifo
  import waste_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  waste_item_t din,
  input  logic        pop,
  output waste_item_t dout,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  waste_item_t    mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    cnt_q, cnt_d;
  logic           do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/waste_code_packer.sv
// Waste code packer: buffers classified items and emits 8-bit code words
// {cat[1:0], sub[1:0], chunk_weight[3:0]} for the sorter, splitting each
// item weight into chunks of at most 15.
//   clk, rst (async, active-low)
//   item_valid/item_ready, item_cat, item_sub, item_weight : item input
//   out_valid/out_ready, out_waste, out_last               : code word output
//   item_cnt, chunk_cnt : saturating statistics, only when WASTE_PACK_STATS_EN
//                         is defined; otherwise tied to 0.
module waste_code_packer
  import waste_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       item_valid,
  output logic       item_ready,
  input  logic [1:0] item_cat,
  input  logic [1:0] item_sub,
  input  logic [7:0] item_weight,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_waste,
  output logic       out_last,
  output logic [7:0] item_cnt,
  output logic [7:0] chunk_cnt
);

  waste_item_t push_item, head;
  logic        fifo_full, fifo_empty, pop;
  logic        hs;

  pack_state_e state_q, state_d;
  logic [7:0]  rem_q, rem_d;        // weight still owed after the current word
  logic [7:0]  out_waste_q, out_waste_d;
  logic        out_last_q, out_last_d;
  logic        out_valid_q, out_valid_d;

  assign push_item = '{cat: item_cat, sub: norm_sub(item_cat, item_sub), weight: item_weight};
  assign item_ready = !fifo_full;
  assign hs = out_valid_q && out_ready;

  waste_item_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (item_valid),
    .din   (push_item),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next word comes either from the owed remainder of the current item
  // (keeping its cat/sub) or from a freshly popped FIFO head.
  always_comb begin
    logic       load;
    logic [3:0] ck;
    logic [7:0] src_w;
    logic [3:0] src_cs;
    state_d     = state_q;
    rem_d       = rem_q;
    out_waste_d = out_waste_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    pop         = 1'b0;
    load        = 1'b0;
    src_w       = head.weight;
    src_cs      = {head.cat, head.sub};
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop  = 1'b1;
          load = 1'b1;
        end
      end
      default: begin
        if (hs) begin
          if (rem_q != 8'd0) begin
            load   = 1'b1;
            src_w  = rem_q;
            src_cs = out_waste_q[7:4];
          end else if (!fifo_empty) begin
            pop  = 1'b1;
            load = 1'b1;
          end else begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end
        end
      end
    endcase
    ck = chunk_of(src_w);
    if (load) begin
      state_d     = ST_EMIT;
      out_valid_d = 1'b1;
      out_waste_d = {src_cs, ck};
      rem_d       = src_w - {4'd0, ck};
      out_last_d  = (src_w == {4'd0, ck});
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= 8'd0;
      out_waste_q <= 8'h00;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      out_waste_q <= out_waste_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_waste = out_waste_q;
  assign out_last  = out_last_q;

`ifdef WASTE_PACK_STATS_EN
  logic [7:0] item_cnt_q, item_cnt_d;
  logic [7:0] chunk_cnt_q, chunk_cnt_d;

  always_comb begin
    item_cnt_d  = item_cnt_q;
    chunk_cnt_d = chunk_cnt_q;
    if (hs && chunk_cnt_q != 8'hFF) chunk_cnt_d = chunk_cnt_q + 8'd1;
    if (hs && out_last_q && item_cnt_q != 8'hFF) item_cnt_d = item_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      item_cnt_q  <= 8'h00;
      chunk_cnt_q <= 8'h00;
    end else begin
      item_cnt_q  <= item_cnt_d;
      chunk_cnt_q <= chunk_cnt_d;
    end
  end

  assign item_cnt  = item_cnt_q;
  assign chunk_cnt = chunk_cnt_q;
`else
  assign item_cnt  = 8'h00;
  assign chunk_cnt = 8'h00;
`endif

endmodule
